// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - one read port of the instruction memory arbiter
// The requester drives req/addr; the arbiter returns the grant and the registered response.
interface imem_arbiter_if #(
  parameter int BUS = 32
);
  logic           req;
  logic [BUS-1:0] addr;
  logic           gnt;
  logic           rvalid;
  logic [BUS-1:0] rdata;
  logic           err;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fetch/debug read arbiter for the shared instruction memory
// Port A (fetch) has priority; port B is forced through after STARVE_LIMIT consecutive losses.
module imem_arbiter #(
  parameter int BUS          = 32,
  parameter int MEMSIZE      = 4096,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  imem_arbiter_if.slave  a_port,
  imem_arbiter_if.slave  b_port,
  output logic [BUS-1:0] mem_addr,
  input  logic [BUS-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // The in-flight access: who owns the next response and whether it is an error.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_OK,
    ST_A_ERR,
    ST_B_OK,
    ST_B_ERR
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  starve_cnt;
  logic           a_gnt_c;
  logic           b_gnt_c;
  logic [BUS-1:0] sel_addr;
  logic           addr_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    a_gnt_c   = 1'b0;
    b_gnt_c   = 1'b0;
    sel_addr  = a_port.addr;
    state_nxt = ST_IDLE;
    if (reset) begin
      if (a_port.req && (!b_port.req || starve_cnt < LIMIT)) begin
        a_gnt_c = 1'b1;
      end else if (b_port.req) begin
        b_gnt_c = 1'b1;
      end
    end
    if (b_gnt_c) begin
      sel_addr = b_port.addr;
    end
    addr_err = (sel_addr[1:0] != 2'b00) ||
               ({2'b00, sel_addr[BUS-1:2]} >= BUS'(MEMSIZE));
    if (a_gnt_c) begin
      state_nxt = addr_err ? ST_A_ERR : ST_A_OK;
    end else if (b_gnt_c) begin
      state_nxt = addr_err ? ST_B_ERR : ST_B_OK;
    end
  end

  assign a_port.gnt = a_gnt_c;
  assign b_port.gnt = b_gnt_c;

  // Counter tracks consecutive cycles in which B asked but A won.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (b_port.req && a_gnt_c) begin
      if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Erroring addresses never reach the array, so mem_addr only follows clean accepts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr <= '0;
    end else if ((a_gnt_c || b_gnt_c) && !addr_err) begin
      mem_addr <= sel_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_port.rvalid <= 1'b0;
      a_port.err    <= 1'b0;
      a_port.rdata  <= '0;
      b_port.rvalid <= 1'b0;
      b_port.err    <= 1'b0;
      b_port.rdata  <= '0;
    end else begin
      a_port.rvalid <= (state == ST_A_OK) || (state == ST_A_ERR);
      a_port.err    <= (state == ST_A_ERR);
      b_port.rvalid <= (state == ST_B_OK) || (state == ST_B_ERR);
      b_port.err    <= (state == ST_B_ERR);
      if (state == ST_A_OK) begin
        a_port.rdata <= mem_rdata;
      end else if (state == ST_A_ERR) begin
        a_port.rdata <= '0;
      end
      if (state == ST_B_OK) begin
        b_port.rdata <= mem_rdata;
      end else if (state == ST_B_ERR) begin
        b_port.rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - randomized self-checking bench for imem_arbiter
module tb_imem_arbiter;

  localparam int BUS     = 32;
  localparam int MEMSIZE = 4096;
  localparam int LIMIT   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [BUS-1:0]  mem_addr;
  logic [BUS-1:0]  mem_rdata;

  imem_arbiter_if #(.BUS(BUS)) a_if ();
  imem_arbiter_if #(.BUS(BUS)) b_if ();

  imem_arbiter #(
    .BUS(BUS),
    .MEMSIZE(MEMSIZE),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_port(a_if),
    .b_port(b_if),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] idx);
    return (idx * 32'h0001_0003) ^ 32'h5A5A_0000 ^ (idx << 20);
  endfunction

  always @(negedge clk) mem_rdata <= memval(mem_addr >> 2);

  int          n_checks = 0;
  int          n_errors = 0;
  int          losses   = 0;
  int          b_wins   = 0;
  bit          pend_v   = 0;
  bit          pend_b   = 0;
  bit          pend_err = 0;
  logic [31:0] pend_idx = 0;
  logic [31:0] e_a_rdata  = 0;
  logic [31:0] e_b_rdata  = 0;
  logic [31:0] e_mem_addr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input bit ar, input logic [31:0] aa,
                      input bit br, input logic [31:0] ba);
    bit          ga, gb, e_av, e_ae, e_bv, e_be, acc_err;
    logic [31:0] acc_addr;
    e_av = 0; e_ae = 0; e_bv = 0; e_be = 0;
    reset     = rn;
    a_if.req  = ar;
    a_if.addr = aa;
    b_if.req  = br;
    b_if.addr = ba;
    #1;
    ga = rn && ar && (!br || losses < LIMIT);
    gb = rn && br && !ga;
    check_eq("a_gnt", a_if.gnt, ga);
    check_eq("b_gnt", b_if.gnt, gb);
    if (gb) b_wins++;
    @(posedge clk);
    #1;
    if (!rn) begin
      losses = 0;
      pend_v = 0;
      e_a_rdata = 0;
      e_b_rdata = 0;
      e_mem_addr = 0;
    end else begin
      e_av = pend_v && !pend_b;
      e_bv = pend_v && pend_b;
      e_ae = e_av && pend_err;
      e_be = e_bv && pend_err;
      if (e_av) e_a_rdata = pend_err ? 32'h0 : memval(pend_idx);
      if (e_bv) e_b_rdata = pend_err ? 32'h0 : memval(pend_idx);
      pend_v = ga || gb;
      if (pend_v) begin
        acc_addr = ga ? aa : ba;
        acc_err  = (acc_addr % 4 != 0) || (acc_addr / 4 >= MEMSIZE);
        pend_b   = gb;
        pend_err = acc_err;
        pend_idx = acc_addr / 4;
        if (!acc_err) e_mem_addr = acc_addr;
      end
      if (br && ga) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
      else losses = 0;
    end
    check_eq("a_rvalid", a_if.rvalid, e_av);
    check_eq("a_err", a_if.err, e_ae);
    check_eq("a_rdata", a_if.rdata, e_a_rdata);
    check_eq("b_rvalid", b_if.rvalid, e_bv);
    check_eq("b_err", b_if.err, e_be);
    check_eq("b_rdata", b_if.rdata, e_b_rdata);
    check_eq("mem_addr", mem_addr, e_mem_addr);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7) return {18'h0, 12'($urandom_range(0, MEMSIZE - 1)), 2'b00};
    if (r == 7) return {18'h0, 12'($urandom_range(0, MEMSIZE - 1)), 2'($urandom_range(1, 3))};
    if (r == 8) return 32'($urandom_range(MEMSIZE, 2 * MEMSIZE)) << 2;
    return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) step(0, 1, $urandom, 1, $urandom);

    // A back-to-back
    step(1, 1, 32'h0, 0, $urandom);
    step(1, 1, 32'h4, 0, $urandom);
    step(1, 1, 32'h8, 0, $urandom);
    step(1, 0, $urandom, 0, $urandom);
    step(1, 0, $urandom, 0, $urandom);

    // Starvation: both continuous
    b_wins = 0;
    for (int i = 0; i < 15; i++) step(1, 1, 32'(4 * i), 1, 32'(32'h400 + 4 * i));
    check_eq("starve_b_share", b_wins, 3);
    step(1, 0, $urandom, 0, $urandom);

    // Errors
    step(1, 1, 32'h2, 0, $urandom);
    step(1, 0, $urandom, 1, 32'(4 * MEMSIZE));
    step(1, 0, $urandom, 0, $urandom);

    // Reset mid-flight
    step(1, 1, 32'h10, 0, $urandom);
    step(0, 1, 32'h10, 1, $urandom);
    step(1, 1, 32'h10, 0, $urandom);
    step(1, 0, $urandom, 0, $urandom);

    // B only then idle
    step(1, 0, $urandom, 1, 32'h20);
    for (int i = 0; i < 3; i++) step(1, 0, $urandom, 0, $urandom);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, rand_addr(),
           $urandom_range(0, 2) != 0, rand_addr());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
